// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c432 core: receives a framed, even-parity key
// stream over valid/ready, commits the key once on a good frame, locks out after repeated failures.
module lock_key_loader #(
  parameter int KEY_W     = 14,
  parameter int X_W       = 10,
  parameter int MAX_TRIES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_start,
  input  logic                 key_bit_in,
  input  logic                 key_bit_valid,
  output logic                 key_bit_ready,
  output logic [X_W-1:0]       key_x,
  output logic [KEY_W-X_W-1:0] key_p,
  output logic                 key_loaded,
  output logic                 key_err,
  output logic                 key_lockout
);

  localparam int CNT_W = $clog2(KEY_W + 2);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CHECK   = 3'd2,
    S_LOCKED  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [KEY_W:0]         shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TRY_W-1:0]       tries_q, tries_d;
  logic [X_W-1:0]         key_x_q, key_x_d;
  logic [KEY_W-X_W-1:0]   key_p_q, key_p_d;
  logic                   loaded_q, loaded_d;
  logic                   err_q, err_d;
  logic                   lockout_q, lockout_d;
  logic                   ready_q, ready_d;
  logic                   accept_s;

  // Even parity over the whole frame (data plus parity bit) must fold to zero.
  function automatic logic frame_parity_ok(input logic [KEY_W:0] frame);
    return ~(^frame);
  endfunction

  assign accept_s = key_bit_valid & ready_q;

  // Next-state and next-output logic; ready/lockout are derived from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tries_d   = tries_q;
    key_x_d   = key_x_q;
    key_p_d   = key_p_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (key_start) begin
          state_d = S_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // A restart wins over a beat arriving in the same cycle.
        if (key_start) begin
          shift_d = '0;
          cnt_d   = '0;
        end else if (accept_s) begin
          shift_d = {key_bit_in, shift_q[KEY_W:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_W)) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_CHECK: begin
        if (frame_parity_ok(shift_q)) begin
          key_x_d  = shift_q[X_W-1:0];
          key_p_d  = shift_q[KEY_W-1:X_W];
          loaded_d = 1'b1;
          err_d    = 1'b0;
          state_d  = S_LOCKED;
        end else begin
          err_d   = 1'b1;
          tries_d = tries_q + TRY_W'(1);
          if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKED:  state_d = S_LOCKED;
      S_LOCKOUT: state_d = S_LOCKOUT;
      default:   state_d = S_IDLE;
    endcase
    ready_d   = (state_d == S_SHIFT);
    lockout_d = (state_d == S_LOCKOUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      tries_q   <= '0;
      key_x_q   <= '0;
      key_p_q   <= '0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
      lockout_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      tries_q   <= tries_d;
      key_x_q   <= key_x_d;
      key_p_q   <= key_p_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
      lockout_q <= lockout_d;
      ready_q   <= ready_d;
    end
  end

  assign key_bit_ready = ready_q;
  assign key_x         = key_x_q;
  assign key_p         = key_p_q;
  assign key_loaded    = loaded_q;
  assign key_err       = err_q;
  assign key_lockout   = lockout_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader: directed scenarios plus randomized frames
// compared against a frame-level behavioural model.
module tb_lock_key_loader;

  localparam int KEY_W     = 14;
  localparam int X_W       = 10;
  localparam int MAX_TRIES = 3;

  logic clk = 1'b0;
  logic rst, key_start, key_bit_in, key_bit_valid;
  logic key_bit_ready, key_loaded, key_err, key_lockout;
  logic [X_W-1:0] key_x;
  logic [KEY_W-X_W-1:0] key_p;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level model: a whole frame either commits, fails, or is ignored.
  logic m_loaded, m_err, m_lockout;
  logic [KEY_W-1:0] m_key;
  int m_tries;

  logic [17:0] obs;
  assign obs = {key_loaded, key_err, key_lockout, key_bit_ready, key_x, key_p};

  always #5 clk = ~clk;

  lock_key_loader #(.KEY_W(KEY_W), .X_W(X_W), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_bit_in(key_bit_in),
    .key_bit_valid(key_bit_valid), .key_bit_ready(key_bit_ready), .key_x(key_x),
    .key_p(key_p), .key_loaded(key_loaded), .key_err(key_err), .key_lockout(key_lockout)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_loaded = 1'b0; m_err = 1'b0; m_lockout = 1'b0; m_key = '0; m_tries = 0;
  endtask

  task automatic model_frame(input logic [KEY_W-1:0] k, input logic par);
    if (m_loaded || m_lockout) return;
    if (((^k) ^ par) == 1'b0) begin
      m_loaded = 1'b1; m_key = k; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
      m_tries++;
      if (m_tries >= MAX_TRIES) m_lockout = 1'b1;
    end
  endtask

  function automatic logic [17:0] model_out();
    logic [X_W-1:0] ex;
    logic [KEY_W-X_W-1:0] ep;
    ex = m_loaded ? m_key[X_W-1:0] : '0;
    ep = m_loaded ? m_key[KEY_W-1:X_W] : '0;
    return {m_loaded, m_err, m_lockout, 1'b0, ex, ep};
  endfunction

  task automatic do_reset;
    rst = 1'b1; key_start = 1'b0; key_bit_valid = 1'b0; key_bit_in = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic start_frame;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
  endtask

  // Drives all KEY_W+1 beats; optionally inserts a valid-low gap before beat stall_at.
  task automatic send_beats(input logic [KEY_W-1:0] k, input logic par,
                            input int stall_at, input int stall_len);
    for (int i = 0; i < KEY_W + 1; i++) begin
      if (i == stall_at) begin
        key_bit_valid = 1'b0;
        key_bit_in = 1'($urandom);
        repeat (stall_len) step();
      end
      key_bit_valid = 1'b1;
      key_bit_in = (i < KEY_W) ? k[i] : par;
      step();
    end
    key_bit_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_start = 1'b0; key_bit_valid = 1'b0; key_bit_in = 1'b0;
    step(); step();
    n_checks++;
    if (obs !== 18'd0) $display("FAIL reset_state: got %h expected %h", obs, 18'd0);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_good_load;
    logic [KEY_W-1:0] k;
    do_reset();
    k = 14'h1AA5;
    start_frame();
    n_checks++;
    if (key_bit_ready !== 1'b1) $display("FAIL good_ready: got %b expected 1", key_bit_ready);
    else n_pass++;
    send_beats(k, 1'b1, -1, 0);
    n_checks++;
    if ({key_loaded, key_bit_ready} !== 2'b00)
      $display("FAIL good_early: got loaded/ready %b expected 00", {key_loaded, key_bit_ready});
    else n_pass++;
    step();
    n_checks++;
    if (obs !== {4'b1000, 10'h2A5, 4'h6})
      $display("FAIL good_commit: got %h expected %h", obs, {4'b1000, 10'h2A5, 4'h6});
    else n_pass++;
  endtask

  task automatic test_bad_parity;
    do_reset();
    start_frame();
    send_beats(14'h1AA5, 1'b0, -1, 0);
    step();
    n_checks++;
    if (obs !== {4'b0100, 14'd0}) $display("FAIL bad_parity: got %h expected %h", obs, {4'b0100, 14'd0});
    else n_pass++;
    start_frame();
    send_beats(14'h1AA5, 1'b1, -1, 0);
    step();
    n_checks++;
    if (obs !== {4'b1000, 10'h2A5, 4'h6})
      $display("FAIL bad_then_good: got %h expected %h", obs, {4'b1000, 10'h2A5, 4'h6});
    else n_pass++;
  endtask

  task automatic test_lockout;
    logic [KEY_W-1:0] k;
    do_reset();
    for (int t = 0; t < MAX_TRIES; t++) begin
      k = KEY_W'($urandom);
      start_frame();
      send_beats(k, ~(^k), -1, 0);
      step();
      model_frame(k, ~(^k));
      n_checks++;
      if (obs !== model_out()) $display("FAIL lockout_try%0d: got %h expected %h", t, obs, model_out());
      else n_pass++;
    end
    n_checks++;
    if (key_lockout !== 1'b1) $display("FAIL lockout_flag: got %b expected 1", key_lockout);
    else n_pass++;
    k = 14'h1AA5;
    start_frame();
    n_checks++;
    if (key_bit_ready !== 1'b0) $display("FAIL lockout_ready: got %b expected 0", key_bit_ready);
    else n_pass++;
    send_beats(k, ^k, -1, 0);
    step();
    n_checks++;
    if (obs !== {4'b0110, 14'd0}) $display("FAIL lockout_ignore: got %h expected %h", obs, {4'b0110, 14'd0});
    else n_pass++;
    do_reset();
    n_checks++;
    if (obs !== 18'd0) $display("FAIL lockout_rst: got %h expected %h", obs, 18'd0);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [KEY_W-1:0] k, junk;
    do_reset();
    k = KEY_W'($urandom);
    junk = ~k;
    start_frame();
    for (int i = 0; i < 7; i++) begin
      key_bit_valid = 1'b1; key_bit_in = junk[i];
      step();
    end
    key_start = 1'b1; key_bit_valid = 1'b1; key_bit_in = 1'b1;
    step();
    key_start = 1'b0; key_bit_valid = 1'b0;
    n_checks++;
    if ({key_bit_ready, key_loaded} !== 2'b10)
      $display("FAIL abort_restart: got ready/loaded %b expected 10", {key_bit_ready, key_loaded});
    else n_pass++;
    send_beats(k, ^k, -1, 0);
    step();
    model_frame(k, ^k);
    n_checks++;
    if (obs !== model_out()) $display("FAIL abort_commit: got %h expected %h", obs, model_out());
    else n_pass++;
  endtask

  task automatic test_stall_postlock;
    logic [KEY_W-1:0] k, k2;
    int cyc;
    do_reset();
    k = KEY_W'($urandom);
    start_frame();
    cyc = 1;
    send_beats(k, ^k, 6, 5);
    cyc += KEY_W + 1 + 5;
    while (key_loaded !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != KEY_W + 3 + 5) $display("FAIL stall_latency: got %0d cycles expected %0d", cyc, KEY_W + 8);
    else n_pass++;
    model_frame(k, ^k);
    n_checks++;
    if (obs !== model_out()) $display("FAIL stall_commit: got %h expected %h", obs, model_out());
    else n_pass++;
    k2 = ~k;
    start_frame();
    send_beats(k2, ^k2, -1, 0);
    step();
    model_frame(k2, ^k2);
    n_checks++;
    if (obs !== model_out()) $display("FAIL post_lock: got %h expected %h", obs, model_out());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [KEY_W-1:0] k;
    do_reset();
    k = KEY_W'($urandom);
    start_frame();
    for (int i = 0; i < 9; i++) begin
      key_bit_valid = 1'b1; key_bit_in = k[i];
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; key_bit_valid = 1'b0;
    n_checks++;
    if (obs !== 18'd0) $display("FAIL rst_mid_frame: got %h expected %h", obs, 18'd0);
    else n_pass++;
    model_reset();
    start_frame();
    send_beats(k, ^k, -1, 0);
    step();
    model_frame(k, ^k);
    n_checks++;
    if (obs !== model_out()) $display("FAIL rst_then_load: got %h expected %h", obs, model_out());
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (obs !== 18'd0) $display("FAIL rst_locked: got %h expected %h", obs, 18'd0);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [KEY_W-1:0] k;
    logic par;
    int nf;
    for (int it = 0; it < 20; it++) begin
      do_reset();
      nf = int'($urandom_range(1, 5));
      for (int f = 0; f < nf; f++) begin
        k = KEY_W'($urandom);
        par = (^k) ^ ($urandom_range(0, 2) == 0);
        start_frame();
        send_beats(k, par, int'($urandom_range(0, 20)), int'($urandom_range(1, 3)));
        step();
        model_frame(k, par);
        n_checks++;
        if (obs !== model_out())
          $display("FAIL random_it%0d_f%0d: got %h expected %h", it, f, obs, model_out());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_load();
    test_bad_parity();
    test_lockout();
    test_abort();
    test_stall_postlock();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
